// File: rtl/sram_stream_fifo_ctrl_pkg.sv
// sram_stream_fifo_ctrl_pkg: shared widths and types for the SRAM-backed stream FIFO
package sram_stream_fifo_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH = 1 << ADDR_W;
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction
  localparam int PTR_W = ptr_w(ADDR_W);
  localparam int LVL_W = ADDR_W + 2;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LVL_W-1:0] lvl_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/sram_stream_fifo_ctrl_if.sv
// sram_stream_fifo_ctrl_if: stream handshake and SRAM wrapper port bundle
interface sram_stream_fifo_ctrl_if;
  import sram_stream_fifo_ctrl_pkg::*;
  logic flush;
  logic in_valid;
  logic in_ready;
  word_t in_data;
  logic out_valid;
  logic out_ready;
  word_t out_data;
  lvl_t level;
  logic mem_W0_en;
  addr_t mem_W0_addr;
  word_t mem_W0_data;
  logic mem_R0_en;
  addr_t mem_R0_addr;
  word_t mem_R0_data;
  modport slave (
    input flush, in_valid, in_data, out_ready, mem_R0_data,
    output in_ready, out_valid, out_data, level,
    output mem_W0_en, mem_W0_addr, mem_W0_data, mem_R0_en, mem_R0_addr
  );
  modport master (
    output flush, in_valid, in_data, out_ready, mem_R0_data,
    input in_ready, out_valid, out_data, level,
    input mem_W0_en, mem_W0_addr, mem_W0_data, mem_R0_en, mem_R0_addr
  );
endinterface

// File: rtl/sram_stream_obuf.sv
// sram_stream_obuf: 2-entry head-first output buffer absorbing the SRAM read latency
module sram_stream_obuf
  import sram_stream_fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic       i_pop,
  input  word_t      i_data,
  output logic       o_valid,
  output word_t      o_data,
  output logic [1:0] o_count,
  output logic [1:0] o_count_nxt
);
  word_t r_m0, r_m1, w_m0, w_m1;
  logic [1:0] r_count, w_idx;
  always_comb begin
    w_idx = r_count - {1'b0, i_pop};
    w_m0 = (i_push && w_idx == 2'd0) ? i_data : i_pop ? r_m1 : r_m0;
    w_m1 = (i_push && w_idx == 2'd1) ? i_data : r_m1;
    o_count_nxt = i_flush ? 2'd0 : r_count + {1'b0, i_push} - {1'b0, i_pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0 <= '0;
      r_m1 <= '0;
      r_count <= '0;
    end else begin
      r_m0 <= w_m0;
      r_m1 <= w_m1;
      r_count <= o_count_nxt;
    end
  end
  assign o_valid = r_count != 2'd0;
  assign o_data = r_m0;
  assign o_count = r_count;
endmodule

// File: rtl/sram_stream_fifo_ctrl.sv
// sram_stream_fifo_ctrl: valid/ready FIFO over a 256x32 dual-port SRAM wrapper
module sram_stream_fifo_ctrl
  import sram_stream_fifo_ctrl_pkg::*;
(
  input logic clk,
  input logic rst_n,
  sram_stream_fifo_ctrl_if.slave bus
);
  ptr_t r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt, w_count, w_count_nxt;
  logic r_inflight, w_in_ready, w_wr, w_issue, w_pop, w_push, w_out_valid;
  logic [1:0] w_ob_count, w_ob_count_nxt;
  logic [2:0] w_occ;
  word_t w_out_data;
  lvl_t r_level;
  // Reads only see the registered write pointer, so a word is never read in its write cycle
  always_comb begin
    w_count = r_wr_ptr - r_rd_ptr;
    w_in_ready = rst_n && !bus.flush && w_count < PTR_W'(DEPTH);
    w_wr = bus.in_valid && w_in_ready;
    w_pop = w_out_valid && bus.out_ready;
    w_occ = 3'(w_ob_count) + 3'(r_inflight) - 3'(w_pop);
    w_issue = w_count != '0 && !bus.flush && w_occ < 3'd2;
    w_push = r_inflight && !bus.flush;
    w_wr_nxt = r_wr_ptr + PTR_W'(w_wr);
    w_rd_nxt = bus.flush ? r_wr_ptr : r_rd_ptr + PTR_W'(w_issue);
    w_count_nxt = w_wr_nxt - w_rd_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_inflight <= 1'b0;
      r_level <= '0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_inflight <= w_issue;
      r_level <= LVL_W'(w_count_nxt) + LVL_W'(w_issue) + LVL_W'(w_ob_count_nxt);
    end
  end
  sram_stream_obuf u_obuf (
    .clk(clk),
    .rst_n(rst_n),
    .i_flush(bus.flush),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(bus.mem_R0_data),
    .o_valid(w_out_valid),
    .o_data(w_out_data),
    .o_count(w_ob_count),
    .o_count_nxt(w_ob_count_nxt)
  );
  assign bus.in_ready = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data = w_out_data;
  assign bus.level = r_level;
  assign bus.mem_W0_en = w_wr;
  assign bus.mem_W0_addr = r_wr_ptr[ADDR_W-1:0];
  assign bus.mem_W0_data = bus.in_data;
  assign bus.mem_R0_en = w_issue;
  assign bus.mem_R0_addr = r_rd_ptr[ADDR_W-1:0];
endmodule

// File: tb/tb_sram_stream_fifo_ctrl.sv
// tb_sram_stream_fifo_ctrl: directed and random checks against a queue model of the FIFO
module tb_sram_stream_fifo_ctrl;
  import sram_stream_fifo_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0, n_err = 0, n_in = 0, n_out = 0;
  word_t q[$];
  word_t mem [DEPTH];
  sram_stream_fifo_ctrl_if bus();
  sram_stream_fifo_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_W0_en) mem[bus.mem_W0_addr] <= bus.mem_W0_data;
    if (bus.mem_R0_en) bus.mem_R0_data <= mem[bus.mem_R0_addr];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  // Model step: the DUT's level must equal words accepted and not yet delivered
  task automatic adv();
    word_t e;
    chk("level", 64'(bus.level), 64'(q.size()));
    chk("occ_le2", 64'(32'(dut.r_inflight) + 32'(dut.w_ob_count) <= 2), 64'd1);
    if (bus.mem_W0_en && bus.mem_R0_en) chk("rw_same_addr", 64'(bus.mem_W0_addr == bus.mem_R0_addr), 64'd0);
    if (bus.flush) chk("flush_ready", 64'(bus.in_ready), 64'd0);
    if (bus.out_valid && bus.out_ready) begin
      chk("out_spurious", 64'(q.size() == 0), 64'd0);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e));
        n_out++;
      end
    end
    if (bus.flush) q.delete();
    if (bus.in_valid && bus.in_ready) begin
      q.push_back(bus.in_data);
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic cyc();
    settle();
    adv();
  endtask
  task automatic drain(input int budget);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < budget && q.size() > 0; c++) cyc();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask
  initial begin
    int n0, o0, acc;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    settle();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_w0_en", 64'(bus.mem_W0_en), 64'd0);
    chk("rst_r0_en", 64'(bus.mem_R0_en), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    // Single word latency
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEADBEEF;
    bus.out_ready = 1'b1;
    settle();
    chk("sw_w0_en", 64'(bus.mem_W0_en), 64'd1);
    chk("sw_w0_addr", 64'(bus.mem_W0_addr), 64'd0);
    chk("sw_r0_idle", 64'(bus.mem_R0_en), 64'd0);
    adv();
    bus.in_valid = 1'b0;
    settle();
    chk("sw_r0_en", 64'(bus.mem_R0_en), 64'd1);
    chk("sw_r0_addr", 64'(bus.mem_R0_addr), 64'd0);
    chk("sw_w0_off", 64'(bus.mem_W0_en), 64'd0);
    chk("sw_ov_e1", 64'(bus.out_valid), 64'd0);
    adv();
    settle();
    chk("sw_ov_e2", 64'(bus.out_valid), 64'd0);
    adv();
    settle();
    chk("sw_ov", 64'(bus.out_valid), 64'd1);
    chk("sw_data", 64'(bus.out_data), 64'hDEADBEEF);
    adv();
    settle();
    chk("sw_level0", 64'(bus.level), 64'd0);
    adv();
    // Streaming 1000 words, no bubbles once flowing
    n0 = n_in;
    o0 = n_out;
    for (int c = 0; c < 1100 && n_out - o0 < 1000; c++) begin
      bus.in_valid = (n_in - n0) < 1000;
      bus.in_data = word_t'(n_in - n0);
      settle();
      if (n_out - o0 > 0) chk("no_bubble", 64'(bus.out_valid), 64'd1);
      adv();
    end
    bus.in_valid = 1'b0;
    chk("stream_cnt", 64'(n_out - o0), 64'd1000);
    drain(20);
    // Full boundary
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    n0 = n_in;
    for (int c = 0; c < 300; c++) begin
      bus.in_data = $urandom;
      cyc();
    end
    acc = n_in - n0;
    chk("full_accepted", 64'(acc), 64'd258);
    settle();
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_level", 64'(bus.level), 64'd258);
    adv();
    drain(400);
    // Random backpressure
    n0 = n_in;
    for (int c = 0; c < 30000 && n_in - n0 < 5000; c++) begin
      bus.in_valid = $urandom_range(9) < 7;
      bus.in_data = $urandom;
      bus.out_ready = $urandom_range(1) == 1;
      cyc();
    end
    chk("rand_accepted", 64'(n_in - n0), 64'd5000);
    drain(600);
    // Flush while a read is in flight
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hAAAA0001;
    cyc();
    bus.in_valid = 1'b0;
    settle();
    chk("fl_r0_en", 64'(bus.mem_R0_en), 64'd1);
    adv();
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hBADBAD00;
    settle();
    chk("fl_no_write", 64'(bus.mem_W0_en), 64'd0);
    adv();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("fl_ov_off", 64'(bus.out_valid), 64'd0);
      adv();
    end
    o0 = n_out;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h1234;
    cyc();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10 && n_out == o0; c++) cyc();
    chk("fl_after_word", 64'(n_out - o0), 64'd1);
    // Asynchronous reset with the output buffer full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.in_data = $urandom;
      cyc();
    end
    settle();
    chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_out_data", 64'(bus.out_data), 64'd0);
    chk("ar_w0_en", 64'(bus.mem_W0_en), 64'd0);
    chk("ar_r0_en", 64'(bus.mem_R0_en), 64'd0);
    chk("ar_in_ready", 64'(bus.in_ready), 64'd0);
    chk("ar_level", 64'(bus.level), 64'd0);
    q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("ar_rel_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    o0 = n_out;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h55AA55AA;
    cyc();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10 && n_out == o0; c++) cyc();
    chk("ar_after_word", 64'(n_out - o0), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sram_stream_fifo_ctrl.md
Name: sram_stream_fifo_ctrl

Overview:
- Single-clock streaming FIFO controller that turns the 256x32 dual-port SRAM macro wrapper into a valid/ready FIFO between spectrometer stages, e.g. FFT output to magnitude/accumulator.
- Drives the wrapper's W0 (write) and R0 (read) ports and absorbs the macro's 1-cycle read latency with a 2-entry output buffer.
- Sustains 1 word/cycle in and out under continuous ready.

Parameters:
- DATA_W, 32, word width; must match the SRAM wrapper.
- ADDR_W, 8, SRAM address width.
- DEPTH, 256, SRAM words; equals 2^ADDR_W.

Ports:
- clock  in  1  sole clock; also drives the wrapper's R0_clk and W0_clk.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all FIFO contents.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  DATA_W  upstream word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  output word.
- level  out  ADDR_W+2  total occupancy: SRAM + in-flight + output buffer.
- mem_W0_en  out  1  to wrapper W0_en.
- mem_W0_addr  out  ADDR_W  to wrapper W0_addr.
- mem_W0_data  out  DATA_W  to wrapper W0_data.
- mem_R0_en  out  1  to wrapper R0_en.
- mem_R0_addr  out  ADDR_W  to wrapper R0_addr.
- mem_R0_data  in  DATA_W  from wrapper R0_data; valid the cycle after mem_R0_en.

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_ptr, rd_ptr, inflight, obuf_count and obuf contents clear to 0.
  - out_valid=0, out_data=0, level=0, mem_W0_en=0, mem_R0_en=0.
  - in_ready=0 while reset_n is low; it is 1 in the first cycle after release.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits and wrap modulo 2*DEPTH.
  - SRAM address is ptr[ADDR_W-1:0].
  - sram_count = wr_ptr - rd_ptr, range 0..DEPTH.
- Write path:
  - in_ready = !flush && sram_count < DEPTH (combinational).
  - On in_valid&&in_ready: mem_W0_en=1, mem_W0_addr=wr_ptr, mem_W0_data=in_data in the same cycle; wr_ptr increments at the edge.
- Read issue:
  - Condition: sram_count>0 && !flush && (obuf_count + inflight - pop) < 2, where pop = out_valid&&out_ready.
  - When the condition holds: mem_R0_en=1, mem_R0_addr=rd_ptr; rd_ptr increments; inflight is set next cycle.
- Read-during-write:
  - sram_count uses the registered wr_ptr, so a word written at edge E is never read before the cycle after E.
  - A same-address simultaneous read and write therefore never occurs.
- Return path:
  - When inflight=1, mem_R0_data is pushed into obuf at the next edge.
  - inflight clears unless a new read was issued in the same cycle.
- Output buffer:
  - 2-entry, head-first.
  - out_valid = obuf_count>0; out_data = head entry.
  - A push and a pop in the same cycle keep obuf_count unchanged.
  - obuf overflow is impossible by the issue rule; verification asserts obuf_count<=2 and inflight+obuf_count<=2.
- Latency:
  - Input handshake at edge E0 -> read issued in cycle E0..E1 -> data captured at E2.
  - out_valid is high in the cycle after E2: 2 cycles minimum after the handshake edge, when empty.
- Throughput: with out_ready held high, one word out per cycle in steady state.
- Full boundary:
  - At sram_count==DEPTH, in_ready=0.
  - A same-cycle read issue does not raise in_ready until the next cycle (registered pointers).
- Empty boundary: with sram_count==0, mem_R0_en=0 and the wrapper holds its last data, which is ignored.
- Flush:
  - At the edge: pointers equalize (rd_ptr<=wr_ptr), obuf_count<=0, inflight<=0.
  - Returning data from a pre-flush read is discarded.
  - flush overrides a simultaneous in_valid: in_ready=0 and no write occurs.
- level = sram_count + inflight + obuf_count, registered, updated every edge.
- Data is never modified; ordering is strictly FIFO.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults and ptr width function (ADDR_W+1), consistent with the other SRAM-wrapped stages.
- One sub-module: sram_stream_obuf, the 2-entry output buffer with push/pop/count.
- Pointer and issue logic stay in the top module.

Test Plan:
- Single word: reset, write 0xDEADBEEF with out_ready=1 -> mem_W0_en one cycle at addr 0, mem_R0_en next cycle at addr 0; out_valid high 2 cycles after the input edge with out_data=0xDEADBEEF; level returns to 0.
- Streaming: 1000 words 0..999 with in_valid and out_ready held 1 -> output identical sequence; after fill, one word per cycle with no bubbles; pointers wrap past 255 correctly.
- Full: out_ready=0, write until in_ready=0 -> exactly 258 accepted (256 SRAM + 2 obuf); level=258; draining returns all 258 in order.
- Backpressure: random out_ready (50%) and in_valid (70%) for 5000 words -> scoreboard match; obuf_count<=2 always; no read/write same-address in the same cycle.
- Flush mid-read: flush asserted in the cycle after mem_R0_en with in_valid=1 -> no write that cycle; next cycle out_valid=0, level=0; the late mem_R0_data is not emitted; subsequent word 0x1234 emerges correctly.
- Async reset mid-stream: drop reset_n between edges with obuf full -> out_valid, mem_W0_en and mem_R0_en go 0 immediately; after release, an empty FIFO accepts 0x55AA55AA and outputs it.
